// File: rtl/jk_register_bank.sv
// WIDTH-bit bank of JK-style state bits with per-cycle JK / LOAD / TOGGLE / COUNT modes.
// Registered edge flags (rise/fall) and a counter wrap pulse accompany every update.
module jk_register_bank #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             wrap
);

  localparam logic [1:0]       MODE_JK     = 2'b00;
  localparam logic [1:0]       MODE_LOAD   = 2'b01;
  localparam logic [1:0]       MODE_TOGGLE = 2'b10;
  localparam logic [1:0]       MODE_COUNT  = 2'b11;
  localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONES    = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO        = {WIDTH{1'b0}};

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] qbar_q, qbar_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] q_nxt;

  // Next-state and flag computation; a disabled cycle holds q and clears the pulses.
  always_comb begin
    q_nxt  = q_q;
    wrap_d = 1'b0;
    if (en) begin
      case (mode)
        // Per-bit JK characteristic equation: Q+ = J & ~Q | ~K & Q.
        MODE_JK:     q_nxt = (j & ~q_q) | (~k & q_q);
        MODE_LOAD:   q_nxt = j;
        MODE_TOGGLE: q_nxt = q_q ^ j;
        MODE_COUNT: begin
          if (up) begin
            q_nxt  = q_q + ONE;
            wrap_d = (q_q == ALL_ONES);
          end else begin
            q_nxt  = q_q - ONE;
            wrap_d = (q_q == ZERO);
          end
        end
        default:     q_nxt = q_q;
      endcase
    end else begin
      q_nxt = q_q;
    end
    q_d    = q_nxt;
    qbar_d = ~q_nxt;
    rise_d = ~q_q & q_nxt;
    fall_d = q_q & ~q_nxt;
  end

  // State and flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q    <= RST_VAL;
      qbar_q <= ~RST_VAL;
      rise_q <= ZERO;
      fall_q <= ZERO;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      qbar_q <= qbar_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      wrap_q <= wrap_d;
    end
  end

  assign q    = q_q;
  assign qbar = qbar_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign wrap = wrap_q;

endmodule
